// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC and PRId, exception entry
// and eret handling for the M stage of the pipeline.
module cp0_exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic [31:0] PC,
    input  logic [4:0]  ExcCode,
    input  logic        BD,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h4D50_3730;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:2] epc_q;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_next;

    // Restart address: a delay-slot victim resumes at its branch (wraps mod 2^32).
    function automatic logic [31:0] victim_pc(input logic [31:0] pc, input logic bd);
        logic [31:0] v;
        v = bd ? (pc - 32'd4) : pc;
        return {v[31:2], 2'b00};
    endfunction

    assign int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend = (ExcCode != 5'd0) & ~sr_exl;
    assign IntReq   = reset & (int_pend | exc_pend);
    assign epc_next = victim_pc(PC, BD);

    assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
    assign EPC        = {epc_q, 2'b00};

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = EPC;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                // Exception entry swallows any concurrent mtc0 and eret.
                sr_exl    <= 1'b1;
                cause_bd  <= BD;
                cause_exc <= int_pend ? 5'd0 : ExcCode;
                epc_q     <= epc_next[31:2];
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (WE && (A2 == REG_EPC)) begin
                    epc_q <= DIn[31:2];
                end
                // Placed last so eret overrides an mtc0 to SR for the EXL bit.
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic [31:0] PC;
    logic [4:0]  ExcCode;
    logic        BD;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int n_tests;
    int n_fail;

    localparam logic [31:0] PRID = 32'h4D50_3730;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .DIn(DIn),
        .PC(PC), .ExcCode(ExcCode), .BD(BD), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; WE = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; PC = 32'd0;
        ExcCode = 5'd3; BD = 1'b0; HWInt = 6'd0; EXLClr = 1'b0;

        // Held in reset: IntReq gated even with an exception code present
        #1;
        check("rst_intreq", {31'd0, IntReq}, 32'd0);
        rd_chk("rst_sr", 5'd12, 32'd0);
        rd_chk("rst_prid", 5'd15, PRID);
        check("rst_epc", EPC, 32'd0);

        #14;
        reset = 1'b1;
        ExcCode = 5'd0;
        tick();
        check("idle_intreq", {31'd0, IntReq}, 32'd0);
        rd_chk("idle_sr", 5'd12, 32'd0);
        rd_chk("idle_cause", 5'd13, 32'd0);
        rd_chk("idle_epc", 5'd14, 32'd0);
        rd_chk("idle_prid", 5'd15, PRID);

        // Plain exception, not in delay slot
        PC = 32'h0000_3008; ExcCode = 5'd4; BD = 1'b0;
        #1;
        check("exc_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 5'd5;
        #1;
        check("exc_epc", EPC, 32'h0000_3008);
        rd_chk("exc_cause", 5'd13, 32'h0000_0010);
        rd_chk("exc_sr", 5'd12, 32'h0000_0002);
        check("exc_masked_by_exl", {31'd0, IntReq}, 32'd0);
        ExcCode = 5'd0;

        // eret clears EXL
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd_chk("eret_sr", 5'd12, 32'd0);

        // mtc0 SR then interrupt in a delay slot
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0;
        rd_chk("mtc0_sr", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001; BD = 1'b1; PC = 32'h0000_3010;
        #1;
        check("int_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        check("int_epc", EPC, 32'h0000_300C);
        rd_chk("int_cause", 5'd13, 32'h8000_0400);
        rd_chk("int_sr", 5'd12, 32'h0000_0403);

        // Masked line still visible in Cause.IP
        HWInt = 6'b100000;
        #1;
        check("masked_intreq", {31'd0, IntReq}, 32'd0);
        tick();
        rd_chk("masked_ip", 5'd13, 32'h8000_8000);

        // eret with an enabled interrupt pending; then interrupt beats exception
        HWInt = 6'b000001; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd_chk("eret2_sr", 5'd12, 32'h0000_0401);
        check("eret2_intreq", {31'd0, IntReq}, 32'd1);
        PC = 32'h0000_300C; BD = 1'b0; ExcCode = 5'd9;
        tick();
        check("prio_epc", EPC, 32'h0000_300C);
        rd_chk("prio_cause", 5'd13, 32'h0000_0400);
        rd_chk("prio_sr", 5'd12, 32'h0000_0403);

        // Exception in the same cycle as an mtc0 to EPC
        HWInt = 6'd0; ExcCode = 5'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234; ExcCode = 5'd10; PC = 32'h0000_3000;
        tick();
        WE = 1'b0; ExcCode = 5'd0;
        check("wlost_epc", EPC, 32'h0000_3000);
        rd_chk("wlost_cause", 5'd13, 32'h0000_0028);

        // eret together with mtc0 SR; read shows pre-edge value
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1;
        rd_chk("no_write_through", 5'd12, 32'h0000_0403);
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        rd_chk("eret_mtc0_sr", 5'd12, 32'h0000_FC01);

        // EPC write alignment and ignored writes
        WE = 1'b1; A2 = 5'd14; DIn = 32'h1235_6787;
        tick();
        check("mtc0_epc", EPC, 32'h1235_6784);
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        rd_chk("ign_cause", 5'd13, 32'h0000_0028);
        A2 = 5'd15;
        tick();
        rd_chk("ign_prid", 5'd15, PRID);
        A2 = 5'd3;
        tick();
        WE = 1'b0;
        rd_chk("ign_unmapped", 5'd3, 32'd0);
        rd_chk("ign_sr", 5'd12, 32'h0000_FC01);

        // Delay-slot victim at PC=0 wraps
        PC = 32'd0; BD = 1'b1; ExcCode = 5'd12;
        #1;
        check("wrap_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 5'd0; BD = 1'b0;
        check("wrap_epc", EPC, 32'hFFFF_FFFC);
        rd_chk("wrap_cause", 5'd13, 32'h8000_0030);

        // eret colliding with exception entry keeps EXL set
        EXLClr = 1'b1;
        tick();
        rd_chk("eret3_sr", 5'd12, 32'h0000_FC01);
        ExcCode = 5'd2; PC = 32'h0000_4000;
        tick();
        EXLClr = 1'b0; ExcCode = 5'd0;
        rd_chk("eret_vs_exc_sr", 5'd12, 32'h0000_FC03);
        check("eret_vs_exc_epc", EPC, 32'h0000_4000);

        // Asynchronous reset between edges with EXL=1
        #2;
        ExcCode = 5'd3;
        reset = 1'b0;
        #1;
        check("arst_intreq", {31'd0, IntReq}, 32'd0);
        rd_chk("arst_sr", 5'd12, 32'd0);
        rd_chk("arst_cause", 5'd13, 32'd0);
        check("arst_epc", EPC, 32'd0);
        rd_chk("arst_prid", 5'd15, PRID);
        reset = 1'b1;
        #1;
        rd_chk("release_sr", 5'd12, 32'd0);
        ExcCode = 5'd0;
        tick();
        rd_chk("post_release_sr", 5'd12, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 WE  input  1  mtc0 write enable from M stage.
REQ-005 A1  input  5  mfc0 read register number.
REQ-006 A2  input  5  mtc0 write register number.
REQ-007 DIn  input  32  mtc0 write data.
REQ-008 PC  input  32  PC of the instruction currently in M stage (victim PC).
REQ-009 ExcCode  input  5  pipelined exception code of M-stage instruction; 0 = none.
REQ-010 BD  input  1  M-stage instruction sits in a branch delay slot.
REQ-011 HWInt  input  6  external hardware interrupt lines.
REQ-012 EXLClr  input  1  eret in M stage; clears EXL.
REQ-013 IntReq  output  1  take exception/interrupt this cycle: flush pipeline, redirect NPC to 0x0000_4180.
REQ-014 EPC  output  32  current EPC register, the eret return target for NPC.
REQ-015 DOut  output  32  mfc0 read data.

Function
REQ-016 Registers: SR (#12) {IM[15:10], EXL[1], IE[0]}; Cause (#13) {BD[31], IP[15:10], ExcCode[6:2]}; EPC (#14); PRId (#15); all other bits read 0.
REQ-017 IntPend = |(HWInt & SR.IM) & SR.IE & !SR.EXL; ExcPend = (ExcCode != 0) & !SR.EXL.
REQ-018 IntReq SHALL be combinational, IntPend | ExcPend, and forced to 0 while reset is low.
REQ-019 On a rising edge with IntReq=1: EXL<=1; Cause.BD<=BD; Cause.ExcCode<=IntPend ? 0 : ExcCode.
REQ-020 On the same edge, EPC SHALL load (BD ? PC-4 : PC) with bits [1:0] forced to 0, using mod-2^32 subtraction (PC=0, BD=1 gives 0xFFFF_FFFC).
REQ-021 Interrupt SHALL have priority over a simultaneous exception; ExcCode is then 0, and EPC still follows REQ-020.
REQ-022 Cause.IP SHALL load HWInt on every rising edge, independent of IntReq and WE.
REQ-023 WE=1 with IntReq=0: A2=12 writes IM/EXL/IE fields of SR from DIn; A2=14 writes EPC with DIn[31:2],2'b00.
REQ-024 Writes to A2 = 13, 15 or unmapped numbers SHALL be ignored.
REQ-025 WE=1 with IntReq=1 in the same cycle: the write is discarded and REQ-019/020 take effect.
REQ-026 EXLClr=1 with IntReq=0 clears EXL on the edge; EXLClr and IntReq together leave EXL=1.
REQ-027 EXLClr together with an mtc0 to SR: EXLClr wins for the EXL bit, and the other SR fields take DIn.
REQ-028 DOut SHALL be a combinational read of A1 showing pre-edge register contents (no write-through); unmapped A1 reads 0.
REQ-029 PRId SHALL read constant 0x4D50_3730.
REQ-030 HWInt masked by IM, IE, or EXL SHALL still appear in Cause.IP.

Reset
REQ-031 While reset is low: SR=0, Cause=0, EPC=0, IntReq=0, DOut reflects the zeroed registers (PRId unchanged).
REQ-032 A reset asserted mid-exception (EXL=1) SHALL clear EXL without waiting for a clock edge.
REQ-033 Release of reset SHALL take effect at the next rising edge; no state change occurs on the release itself.

Verification
REQ-034 Reset low, then high; ExcCode=0, HWInt=0 -> IntReq=0; DOut for A1=12/13/14 = 0; A1=15 = 0x4D50_3730.
REQ-035 ExcCode=4, PC=0x3008, BD=0 -> IntReq=1 same cycle; after edge EPC=0x3008, Cause=0x0000_0010, EXL=1; then ExcCode=5 -> IntReq=0.
REQ-036 mtc0 SR=0x0000_0401, HWInt=6'b000001, BD=1, PC=0x3010 -> IntReq=1; after edge Cause.ExcCode=0, BD=1, EPC=0x300C.
REQ-037 Same cycle WE=1, A2=14, DIn=0x1234, ExcCode=10, PC=0x3000 -> EPC=0x3000, write lost.
REQ-038 EXL=1, EXLClr=1 with pending enabled interrupt -> EXL=0 after edge; IntReq=1 next cycle; EPC holds the eret-target PC.
REQ-039 Assert reset between edges while EXL=1 -> IntReq and SR read 0 immediately.
